// File: rtl/base_apack.sv
// base_apack: packs consecutive single-width beats into {d0,d1} pairs.
// d0 is the earlier beat. i_e ends a group, so an odd group emits a half pair.
module base_apack #(
  parameter int width = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_v,
  output logic             i_r,
  input  logic [width-1:0] i_d,
  input  logic             i_e,
  output logic             o_v,
  input  logic             o_r,
  output logic [width-1:0] o_d0,
  output logic [width-1:0] o_d1,
  output logic             o_v1,
  output logic             o_e
);

  // state | meaning
  // EMPTY | no beat held in the half register
  // FIRST | first beat of a pair held in h_d, waiting for its partner
  // LONE  | group-ending beat held in h_d, waiting for the output register

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FIRST = 2'd1,
    LONE  = 2'd2
  } half_t;

  half_t            state;
  half_t            state_nxt;
  logic [width-1:0] h_d;
  logic             h_v;
  logic             h_e;
  logic             out_free;
  logic             acc;
  logic             load;
  logic             h_d_ld;
  logic [width-1:0] ld_d0;
  logic [width-1:0] ld_d1;
  logic             ld_v1;
  logic             ld_e;

  assign h_v      = (state != EMPTY);
  assign h_e      = (state == LONE);
  assign out_free = ~o_v | o_r;
  // Ready looks only at held state and the output side, never at i_v/i_d/i_e.
  assign i_r      = reset & (~h_v | (out_free & ~h_e));
  assign acc      = i_v & i_r;

  // Decide the output load and next half-register state for this cycle.
  always_comb begin
    state_nxt = state;
    h_d_ld    = 1'b0;
    load      = 1'b0;
    ld_d0     = '0;
    ld_d1     = '0;
    ld_v1     = 1'b0;
    ld_e      = 1'b0;
    case (state)
      EMPTY: begin
        if (acc) begin
          if (!i_e) begin
            state_nxt = FIRST;
            h_d_ld    = 1'b1;
          end else if (out_free) begin
            load  = 1'b1;
            ld_d0 = i_d;
            ld_e  = 1'b1;
          end else begin
            state_nxt = LONE;
            h_d_ld    = 1'b1;
          end
        end
      end
      FIRST: begin
        // acc here implies out_free, so the pair can always be loaded.
        if (acc) begin
          load      = 1'b1;
          ld_d0     = h_d;
          ld_d1     = i_d;
          ld_v1     = 1'b1;
          ld_e      = i_e;
          state_nxt = EMPTY;
        end
      end
      LONE: begin
        if (out_free) begin
          load      = 1'b1;
          ld_d0     = h_d;
          ld_e      = 1'b1;
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Half register and output register; output fields hold while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
      h_d   <= '0;
      o_v   <= 1'b0;
      o_d0  <= '0;
      o_d1  <= '0;
      o_v1  <= 1'b0;
      o_e   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (h_d_ld) h_d <= i_d;
      if (load) begin
        o_v  <= 1'b1;
        o_d0 <= ld_d0;
        o_d1 <= ld_d1;
        o_v1 <= ld_v1;
        o_e  <= ld_e;
      end else if (out_free) begin
        o_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_base_apack.sv
// tb_base_apack: directed table, hand sequences and random traffic for base_apack.
// The reference model treats the block as a pairing function feeding a
// two-deep pair buffer.
module tb_base_apack;
  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic         i_v   = 1'b0;
  logic         i_e   = 1'b0;
  logic         o_r   = 1'b0;
  logic [W-1:0] i_d   = '0;
  logic         i_r;
  logic         o_v;
  logic         o_v1;
  logic         o_e;
  logic [W-1:0] o_d0;
  logic [W-1:0] o_d1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic         v1;
    logic         e;
  } pair_t;

  typedef struct {
    logic         iv;
    logic [W-1:0] id;
    logic         ie;
    logic         orr;
    logic         x_ir;
    logic         x_ov;
    logic [W-1:0] x_d0;
    logic [W-1:0] x_d1;
    logic         x_v1;
    logic         x_e;
  } vec_t;

  pair_t        q[$];
  logic         half_v = 1'b0;
  logic [W-1:0] half_d = '0;
  vec_t         tbl[11];

  base_apack #(.width(W)) dut (
    .clk  (clk),
    .reset(reset),
    .i_v  (i_v),
    .i_r  (i_r),
    .i_d  (i_d),
    .i_e  (i_e),
    .o_v  (o_v),
    .o_r  (o_r),
    .o_d0 (o_d0),
    .o_d1 (o_d1),
    .o_v1 (o_v1),
    .o_e  (o_e)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Ready when the pair buffer has room and a held first beat can complete.
  function automatic logic model_ir();
    return reset && (q.size() < 2) && (!half_v || q.size() == 0 || o_r);
  endfunction

  task automatic model_check(input string tag);
    if (!reset) begin
      q.delete();
      half_v = 1'b0;
    end
    chk({tag, " i_r"}, 32'(i_r), 32'(model_ir()));
    chk({tag, " o_v"}, 32'(o_v), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk({tag, " o_d0"}, 32'(o_d0), 32'(q[0].d0));
      chk({tag, " o_d1"}, 32'(o_d1), 32'(q[0].d1));
      chk({tag, " o_v1"}, 32'(o_v1), 32'(q[0].v1));
      chk({tag, " o_e"},  32'(o_e),  32'(q[0].e));
    end
  endtask

  task automatic model_edge();
    logic acc;
    logic hs;
    pair_t p;
    if (!reset) begin
      q.delete();
      half_v = 1'b0;
      return;
    end
    acc = i_v && model_ir();
    hs  = (q.size() > 0) && o_r;
    if (hs) void'(q.pop_front());
    if (acc) begin
      if (half_v) begin
        p.d0 = half_d; p.d1 = i_d; p.v1 = 1'b1; p.e = i_e;
        q.push_back(p);
        half_v = 1'b0;
      end else if (i_e) begin
        p.d0 = i_d; p.d1 = '0; p.v1 = 1'b0; p.e = 1'b1;
        q.push_back(p);
      end else begin
        half_v = 1'b1;
        half_d = i_d;
      end
    end
  endtask

  task automatic sample(input string tag);
    @(negedge clk);
    model_check(tag);
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step(input string tag);
    sample(tag);
    advance();
  endtask

  task automatic chk_out(input string tag, input logic [W-1:0] d0, input logic [W-1:0] d1,
                         input logic v1, input logic e);
    chk({tag, " o_v"},  32'(o_v),  32'd1);
    chk({tag, " o_d0"}, 32'(o_d0), 32'(d0));
    chk({tag, " o_d1"}, 32'(o_d1), 32'(d1));
    chk({tag, " o_v1"}, 32'(o_v1), 32'(v1));
    chk({tag, " o_e"},  32'(o_e),  32'(e));
  endtask

  initial begin
    // iv id ie orr | x_ir x_ov x_d0 x_d1 x_v1 x_e
    tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 8'h22, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h33, 8'h44, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 8'hA0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 8'hA1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 8'hA2, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA0, 8'hA1, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA2, 8'h00, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};

    // Reset held with traffic offered: everything quiet and zero.
    reset = 1'b0; i_v = 1'b1; i_d = 8'h5A; o_r = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sample("rst");
      chk("rst i_r", 32'(i_r), 32'd0);
      chk("rst o_v", 32'(o_v), 32'd0);
      chk("rst o_d", 32'({o_d0, o_d1}), 32'd0);
      chk("rst o_v1_e", 32'({o_v1, o_e}), 32'd0);
      advance();
    end
    reset = 1'b1; i_v = 1'b0;
    sample("rel");
    chk("rel i_r", 32'(i_r), 32'd1);
    advance();

    // Streaming and odd-group table.
    for (int k = 0; k < 11; k++) begin
      i_v = tbl[k].iv; i_d = tbl[k].id; i_e = tbl[k].ie; o_r = tbl[k].orr;
      sample($sformatf("tbl%0d", k));
      chk($sformatf("tbl%0d i_r", k), 32'(i_r), 32'(tbl[k].x_ir));
      if (tbl[k].x_ov)
        chk_out($sformatf("tbl%0d", k), tbl[k].x_d0, tbl[k].x_d1, tbl[k].x_v1, tbl[k].x_e);
      else
        chk($sformatf("tbl%0d o_v", k), 32'(o_v), 32'd0);
      advance();
    end

    // Backpressure: pair held, one beat buffered, then stall.
    o_r = 1'b0; i_v = 1'b1; i_e = 1'b0;
    i_d = 8'h01; step("bp_a");
    i_d = 8'h02; step("bp_b");
    i_d = 8'h05;
    sample("bp_c");
    chk("bp 05 i_r", 32'(i_r), 32'd1);
    chk_out("bp held", 8'h01, 8'h02, 1'b1, 1'b0);
    advance();
    i_d = 8'h06;
    for (int k = 0; k < 10; k++) begin
      sample("bp_stall");
      chk($sformatf("bp stall%0d i_r", k), 32'(i_r), 32'd0);
      chk_out($sformatf("bp stall%0d", k), 8'h01, 8'h02, 1'b1, 1'b0);
      advance();
    end
    o_r = 1'b1;
    sample("bp_go");
    chk("bp 06 i_r", 32'(i_r), 32'd1);
    advance();
    i_v = 1'b0;
    sample("bp_out");
    chk_out("bp pair", 8'h05, 8'h06, 1'b1, 1'b0);
    advance();
    step("bp_idle");

    // LONE path: group-ending beat arrives while the output is blocked.
    o_r = 1'b0; i_v = 1'b1; i_e = 1'b0;
    i_d = 8'h01; step("ln_a");
    i_d = 8'h02; step("ln_b");
    i_d = 8'h7F; i_e = 1'b1;
    sample("ln_c");
    chk("ln 7f i_r", 32'(i_r), 32'd1);
    advance();
    i_v = 1'b0; i_e = 1'b0;
    sample("ln_d");
    chk("ln lone i_r", 32'(i_r), 32'd0);
    chk_out("ln held", 8'h01, 8'h02, 1'b1, 1'b0);
    advance();
    o_r = 1'b1;
    sample("ln_e");
    chk("ln drain i_r", 32'(i_r), 32'd0);
    advance();
    o_r = 1'b0;
    sample("ln_f");
    chk_out("ln half", 8'h7F, 8'h00, 1'b0, 1'b1);
    chk("ln after i_r", 32'(i_r), 32'd1);
    advance();
    o_r = 1'b1;
    step("ln_g");
    step("ln_h");

    // Mid-group reset discards the held first beat.
    i_v = 1'b1; i_e = 1'b0; i_d = 8'h33;
    step("mr_a");
    i_v = 1'b0; reset = 1'b0;
    sample("mr_b");
    chk("mr rst i_r", 32'(i_r), 32'd0);
    chk("mr rst o_v", 32'(o_v), 32'd0);
    advance();
    reset = 1'b1; i_v = 1'b1; i_d = 8'h01;
    sample("mr_c");
    chk("mr rel i_r", 32'(i_r), 32'd1);
    advance();
    i_d = 8'h02; step("mr_d");
    i_v = 1'b0;
    sample("mr_e");
    chk_out("mr pair", 8'h01, 8'h02, 1'b1, 1'b0);
    advance();
    sample("mr_f");
    chk("mr after o_v", 32'(o_v), 32'd0);
    advance();

    // Random traffic against the model, with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      i_v   = ($urandom_range(0, 3) != 0);
      i_d   = W'($urandom);
      i_e   = ($urandom_range(0, 2) == 0);
      o_r   = ($urandom_range(0, 2) != 0);
      reset = ($urandom_range(0, 199) != 0);
      step("rnd");
    end
    reset = 1'b1; i_v = 1'b0; o_r = 1'b1;
    step("end_a");
    step("end_b");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
